// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: credit-limited memory requests feeding an in-order instruction queue.
// Define RISCV_FETCH_PERF_CNT_EN to enable the fetch_stall_cnt starvation counter.
module riscv_fetch_unit #(
  parameter int                    RISCV_XLEN      = 32,
  parameter int                    RISCV_INSTR_LEN = 32,
  parameter logic [RISCV_XLEN-1:0] RESET_PC        = '0,
  parameter int                    DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  output logic [RISCV_XLEN-1:0]      imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [RISCV_INSTR_LEN-1:0] imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [RISCV_XLEN-1:0]      redirect_pc,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [RISCV_INSTR_LEN-1:0] if_instr,
  output logic [RISCV_XLEN-1:0]      if_pc,
  output logic [31:0]                fetch_stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [RISCV_XLEN-1:0]      pc;
    logic [RISCV_INSTR_LEN-1:0] instr;
  } entry_t;

  entry_t                queue [DEPTH];
  logic [AW-1:0]         head, tail;
  logic [CW-1:0]         qCount, outstanding, dropCnt;
  logic [RISCV_XLEN-1:0] fetchPc, rspPc;
  logic                  reqFire, rspDrop, push, pop;

  // outstanding includes requests whose responses will be dropped, so every
  // accepted request always has a reserved queue slot
  assign imem_req_valid = !rst && !redirect_valid && ((outstanding + qCount) < DEPTH_C);
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid && imem_req_ready;
  assign rspDrop        = imem_rsp_valid && (dropCnt != '0);
  assign push           = imem_rsp_valid && (dropCnt == '0) && !redirect_valid;
  assign pop            = if_valid && if_ready && !redirect_valid;

  // Live requests are consecutive words ending just below fetchPc, so the
  // oldest one's PC follows from the count still in flight.
  assign rspPc = fetchPc - (RISCV_XLEN'(outstanding - dropCnt) << 2);

  assign if_valid = (qCount != '0);
  assign if_instr = queue[head].instr;
  assign if_pc    = queue[head].pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      qCount      <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
    end else if (redirect_valid) begin
      fetchPc     <= {redirect_pc[RISCV_XLEN-1:2], 2'b00};
      head        <= '0;
      tail        <= '0;
      qCount      <= '0;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      dropCnt     <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (reqFire) fetchPc <= fetchPc + RISCV_XLEN'(4);
      outstanding <= outstanding + CW'(reqFire) - CW'(imem_rsp_valid);
      if (rspDrop) dropCnt <= dropCnt - CW'(1);
      if (push)    tail    <= tail + AW'(1);
      if (pop)     head    <= head + AW'(1);
      qCount <= qCount + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) queue[tail] <= '{pc: rspPc, instr: imem_rsp_data};
  end

`ifdef RISCV_FETCH_PERF_CNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       stallCnt <= '0;
    else if (!if_valid && if_ready && stallCnt != '1) stallCnt <= stallCnt + 32'd1;
  end

  assign fetch_stall_cnt = stallCnt;
`else
  assign fetch_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Randomized bench for riscv_fetch_unit: memory model plus a program-order scoreboard.
module tb_riscv_fetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
`ifdef RISCV_FETCH_PERF_CNT_EN
  localparam int STALL_STEP = 1;
`else
  localparam int STALL_STEP = 0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, if_valid, if_ready;
  logic [31:0] redirect_pc, if_instr, if_pc, fetch_stall_cnt;

  riscv_fetch_unit #(.RISCV_XLEN(32), .RISCV_INSTR_LEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_stall_cnt(fetch_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } memReq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ifEnt_t;

  memReq_t     pending[$];
  ifEnt_t      expQ[$];
  logic [31:0] popPc[$];
  int          popCyc[$];
  int          checks = 0, failures = 0, cyc = 0, epoch = 0, reqFires = 0, totalPops = 0;
  logic [31:0] expReqPc = RST_PC, expStall = 0, redirNextPc = 0;
  bit          prevHold = 0, firstCyc = 0, memHold = 0, redirNext = 0;
  int          readyPct = 100, ifReadyPct = 100, maxLat = 1;
  logic [31:0] wrapSeq [4];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    imem_req_ready = ($urandom_range(99) < 32'(readyPct));
    if_ready       = ($urandom_range(99) < 32'(ifReadyPct));
    redirect_valid = redirNext;
    redirect_pc    = redirNextPc;
    redirNext      = 0;
    if (!memHold && pending.size() != 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(pending[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Evaluated mid-cycle: checks outputs, then applies what the next edge does.
  task automatic monitor();
    ifEnt_t  e;
    memReq_t m;
    bit      redir;
    redir = redirect_valid;
    chk("stall_cnt", fetch_stall_cnt, expStall);
    chk("if_valid", 32'(if_valid), 32'(expQ.size() != 0));
    if (firstCyc) begin
      chk("first_req", 32'(imem_req_valid), 32'd1);
      firstCyc = 0;
    end
    if (redir) chk("req_vld_redir", 32'(imem_req_valid), 32'd0);
    if (prevHold && !redir) chk("req_hold", 32'(imem_req_valid), 32'd1);
    if (imem_req_valid) begin
      chk("req_addr", imem_req_addr, expReqPc);
      chk("credit", 32'((pending.size() + expQ.size()) < DEPTH), 32'd1);
    end
    if (!redir && if_valid && if_ready && expQ.size() != 0) begin
      e = expQ.pop_front();
      chk("if_pc", if_pc, e.pc);
      chk("if_instr", if_instr, e.instr);
      popPc.push_back(if_pc);
      popCyc.push_back(cyc);
      totalPops++;
    end
    if (imem_rsp_valid && pending.size() != 0) begin
      m = pending.pop_front();
      if (!redir && m.epoch == epoch) expQ.push_back('{m.addr, memf(m.addr)});
    end
    if (imem_req_valid && imem_req_ready && !redir) begin
      pending.push_back('{expReqPc, epoch, cyc + int'($urandom_range(maxLat, 1))});
      expReqPc += 32'd4;
      reqFires++;
    end
    prevHold = imem_req_valid && !imem_req_ready && !redir;
    if (redir) begin
      expQ.delete();
      epoch++;
      expReqPc = {redirect_pc[31:2], 2'b00};
    end
    if (!if_valid && if_ready && expStall != 32'hFFFF_FFFF) expStall += 32'(STALL_STEP);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic doReset();
    rst = 1'b1;
    pending.delete();
    expQ.delete();
    epoch++;
    expReqPc = RST_PC;
    expStall = 0;
    prevHold = 0;
    redirNext = 0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_stall", fetch_stall_cnt, 32'd0);
    rst = 1'b0;
    firstCyc = 1;
    cyc++;
    drive();
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic asyncReset();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_if_valid", 32'(if_valid), 32'd0);
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    doReset();
  endtask

  initial begin
    int s0;
    wrapSeq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; if_ready = 0;

    // Streaming with 1-cycle memory, PC wraps past 0xFFFFFFFC
    doReset();
    popPc.delete(); popCyc.delete();
    repeat (8) tick();
    if (popPc.size() < 4) chk("stream_cnt", 32'(popPc.size()), 32'd4);
    else for (int i = 0; i < 4; i++) begin
      chk("stream_pc", popPc[i], wrapSeq[i]);
      if (i > 0) chk("stream_gap", 32'(popCyc[i] - popCyc[i-1]), 32'd1);
    end

    // Pipeline back-pressure fills exactly DEPTH entries
    ifReadyPct = 0;
    reqFires = 0;
    doReset();
    popPc.delete();
    repeat (10) tick();
    chk("bp_fires", 32'(reqFires), 32'd4);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_if_valid", 32'(if_valid), 32'd1);
    ifReadyPct = 100;
    for (int i = 0; i < 30 && popPc.size() < 4; i++) tick();
    if (popPc.size() < 4) chk("bp_drain_cnt", 32'(popPc.size()), 32'd4);
    else for (int i = 0; i < 4; i++) chk("bp_order", popPc[i], wrapSeq[i]);

    // Redirect with 3 requests outstanding; low target bits ignored
    memHold = 1;
    reqFires = 0;
    doReset();
    for (int i = 0; i < 20 && reqFires < 3; i++) tick();
    chk("redir_setup", 32'(reqFires), 32'd3);
    readyPct = 0;
    imem_req_ready = 1'b0;
    redirNext = 1;
    redirNextPc = 32'h0000_0103;
    tick();
    memHold = 0;
    readyPct = 100;
    popPc.delete();
    for (int i = 0; i < 30 && popPc.size() < 1; i++) tick();
    if (popPc.size() < 1) chk("redir_timeout", 32'd0, 32'd1);
    else chk("redir_pc", popPc[0], 32'h0000_0100);

    // Starved pipeline: memory silent for 5 cycles
    memHold = 1;
    doReset();
    tick();
    s0 = int'(fetch_stall_cnt);
    repeat (5) tick();
    chk("stall_delta", fetch_stall_cnt - 32'(s0), 32'(5 * STALL_STEP));
    memHold = 0;

    // Random traffic, redirects and an asynchronous reset mid-burst
    doReset();
    for (int ph = 0; ph < 6; ph++) begin
      readyPct   = int'($urandom_range(100, 30));
      ifReadyPct = int'($urandom_range(100, 20));
      maxLat     = int'($urandom_range(4, 1));
      repeat (400) begin
        if ($urandom_range(99) < 3) begin
          redirNext = 1;
          redirNextPc = $urandom;
        end
        tick();
      end
      if (ph == 2) asyncReset();
    end
    readyPct = 100; ifReadyPct = 100;
    repeat (30) tick();
    chk("progress", 32'(totalPops > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
